// File: rtl/half_add_sub_arb_pkg.sv
// Shared types and default configuration for the half_add_sub shared-core arbiter.
package half_add_sub_arb_pkg;

   localparam int DEF_NUM_REQ        = 4;
   localparam int DEF_OPW            = 1;
   localparam int DEF_TIMEOUT_CYCLES = 64;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } arb_state_e;

   // Response record at the default operand width.
   typedef struct packed {
      logic [DEF_OPW-1:0] result;
      logic               carry;
      logic               err;
   } arb_resp_t;

endpackage

// File: rtl/half_add_sub_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after rr_ptr, wrapping.
module rr_arbiter #(
   parameter  int NUM_REQ = 4,
   localparam int IDXW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDXW-1:0]    rr_ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [IDXW-1:0]    index
);

   logic            found_s;
   logic [IDXW-1:0] pos_s;

   // Scan requesters starting at rr_ptr and keep the first hit.
   always_comb begin
      grant   = '0;
      index   = '0;
      found_s = 1'b0;
      pos_s   = '0;
      for (int off = 0; off < NUM_REQ; off++) begin
         pos_s = IDXW'((int'(rr_ptr) + off) % NUM_REQ);
         if (!found_s && req[pos_s]) begin
            found_s      = 1'b1;
            grant[pos_s] = 1'b1;
            index        = pos_s;
         end else begin
            found_s = found_s;
         end
      end
   end

endmodule

// File: rtl/half_add_sub_arbiter.sv
// Round-robin sequencer sharing one ap_ctrl_hs half_add_sub core between NUM_REQ requesters.
// Optional watchdog: define HALF_ADD_SUB_ARB_TIMEOUT_EN.
module half_add_sub_arbiter
   import half_add_sub_arb_pkg::*;
#(
   parameter int NUM_REQ        = DEF_NUM_REQ,
   parameter int OPW            = DEF_OPW,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic [NUM_REQ-1:0]     req,
   input  logic [NUM_REQ*OPW-1:0] req_a,
   input  logic [NUM_REQ*OPW-1:0] req_b,
   input  logic [NUM_REQ-1:0]     req_sub,
   output logic [NUM_REQ-1:0]     gnt,
   output logic [NUM_REQ-1:0]     resp_valid,
   output logic [OPW-1:0]         resp_result,
   output logic                   resp_carry,
   output logic                   resp_err,
   output logic                   core_ap_start,
   input  logic                   core_ap_ready,
   input  logic                   core_ap_done,
   output logic [OPW-1:0]         core_a,
   output logic [OPW-1:0]         core_b,
   output logic                   core_sub,
   input  logic [OPW-1:0]         core_result,
   input  logic                   core_carry,
   output logic                   busy
);

   localparam int IDXW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   if (NUM_REQ < 2 || NUM_REQ > 16 || OPW < 1 || TIMEOUT_CYCLES < 2) begin : g_bad_params
      $error("half_add_sub_arbiter: illegal parameter set");
   end

   arb_state_e         state_r, state_next_s;
   logic [IDXW-1:0]    rr_ptr_r, idx_r, arb_idx_s;
   logic [NUM_REQ-1:0] arb_grant_s, gnt_r, resp_valid_r;
   logic [OPW-1:0]     sel_a_s, sel_b_s, core_a_r, core_b_r, resp_result_r;
   logic               sel_sub_s, core_sub_r, core_ap_start_r, busy_r;
   logic               resp_carry_r, resp_err_r;
   logic               arb_valid_s, capture_s, timeout_s, tmo_hit_s;

   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr_arbiter (
      .req    (req),
      .rr_ptr (rr_ptr_r),
      .grant  (arb_grant_s),
      .index  (arb_idx_s)
   );

   assign arb_valid_s = |req;

   // Operand mux for the requester chosen by the arbiter.
   always_comb begin
      sel_a_s   = '0;
      sel_b_s   = '0;
      sel_sub_s = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (arb_idx_s == IDXW'(i)) begin
            sel_a_s   = req_a[i*OPW +: OPW];
            sel_b_s   = req_b[i*OPW +: OPW];
            sel_sub_s = req_sub[i];
         end else begin
            sel_sub_s = sel_sub_s;
         end
      end
   end

`ifdef HALF_ADD_SUB_ARB_TIMEOUT_EN
   localparam int TOW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TOW-1:0] tmo_cnt_r;

   // Counts cycles spent waiting on the core; restarts for each transaction.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         tmo_cnt_r <= '0;
      end else if (state_r == ST_ISSUE || state_r == ST_WAIT) begin
         tmo_cnt_r <= tmo_cnt_r + TOW'(1);
      end else begin
         tmo_cnt_r <= '0;
      end
   end

   assign tmo_hit_s = (tmo_cnt_r == TOW'(TIMEOUT_CYCLES - 1));
`else
   assign tmo_hit_s = 1'b0;
`endif

   // Next-state logic; a core exit condition always beats the watchdog.
   always_comb begin
      state_next_s = state_r;
      capture_s    = 1'b0;
      timeout_s    = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (arb_valid_s) begin
               state_next_s = ST_ISSUE;
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         ST_ISSUE: begin
            if (core_ap_ready && core_ap_done) begin
               state_next_s = ST_RESP;
               capture_s    = 1'b1;
            end else if (core_ap_ready) begin
               state_next_s = ST_WAIT;
            end else if (tmo_hit_s) begin
               state_next_s = ST_RESP;
               timeout_s    = 1'b1;
            end else begin
               state_next_s = ST_ISSUE;
            end
         end
         ST_WAIT: begin
            if (core_ap_done) begin
               state_next_s = ST_RESP;
               capture_s    = 1'b1;
            end else if (tmo_hit_s) begin
               state_next_s = ST_RESP;
               timeout_s    = 1'b1;
            end else begin
               state_next_s = ST_WAIT;
            end
         end
         ST_RESP: state_next_s = ST_IDLE;
         default: state_next_s = ST_IDLE;
      endcase
   end

   // State register and outputs derived from the upcoming state.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_r         <= ST_IDLE;
         core_ap_start_r <= 1'b0;
         busy_r          <= 1'b0;
         resp_valid_r    <= '0;
      end else begin
         state_r         <= state_next_s;
         core_ap_start_r <= (state_next_s == ST_ISSUE);
         busy_r          <= (state_next_s != ST_IDLE);
         resp_valid_r    <= (state_next_s == ST_RESP) ? gnt_r : '0;
      end
   end

   // Grant, latched operands and round-robin pointer.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         gnt_r      <= '0;
         idx_r      <= '0;
         rr_ptr_r   <= '0;
         core_a_r   <= '0;
         core_b_r   <= '0;
         core_sub_r <= 1'b0;
      end else if (state_r == ST_IDLE && arb_valid_s) begin
         gnt_r      <= arb_grant_s;
         idx_r      <= arb_idx_s;
         core_a_r   <= sel_a_s;
         core_b_r   <= sel_b_s;
         core_sub_r <= sel_sub_s;
      end else if (state_r == ST_RESP) begin
         gnt_r <= '0;
         if (idx_r == IDXW'(NUM_REQ - 1)) begin
            rr_ptr_r <= '0;
         end else begin
            rr_ptr_r <= idx_r + IDXW'(1);
         end
      end else begin
         gnt_r <= gnt_r;
      end
   end

   // Response payload: held between responses, zeroed with err on a timeout.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         resp_result_r <= '0;
         resp_carry_r  <= 1'b0;
         resp_err_r    <= 1'b0;
      end else if (capture_s) begin
         resp_result_r <= core_result;
         resp_carry_r  <= core_carry;
         resp_err_r    <= 1'b0;
      end else if (timeout_s) begin
         resp_result_r <= '0;
         resp_carry_r  <= 1'b0;
         resp_err_r    <= 1'b1;
      end else begin
         resp_err_r <= resp_err_r;
      end
   end

   assign gnt           = gnt_r;
   assign resp_valid    = resp_valid_r;
   assign resp_result   = resp_result_r;
   assign resp_carry    = resp_carry_r;
   assign resp_err      = resp_err_r;
   assign core_ap_start = core_ap_start_r;
   assign core_a        = core_a_r;
   assign core_b        = core_b_r;
   assign core_sub      = core_sub_r;
   assign busy          = busy_r;

endmodule
